// File: rtl/wave_sequencer_if.sv
// Bus between the profile sequencer and its host/WaveGenerator side.
// The slave modport is the sequencer; the master modport drives config and start/stop.
interface wave_sequencer_if #(
  parameter int unsigned N  = 32,
  parameter int unsigned D  = 24,
  parameter int unsigned AW = 3
);
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [1:0]    cfg_wave_sel;
  logic [N-1:0]  cfg_freq;
  logic [N-1:0]  cfg_duty;
  logic [D-1:0]  cfg_dwell;
  logic [AW-1:0] last_idx;
  logic          loop_en;
  logic          start;
  logic          stop;
  logic [1:0]    wave_sel;
  logic [N-1:0]  freq_ctrl;
  logic [N-1:0]  duty_cycle;
  logic          gen_rst;
  logic          busy;
  logic          done;
  logic [AW-1:0] cur_idx;

  modport slave (
    input  cfg_we, cfg_addr, cfg_wave_sel, cfg_freq, cfg_duty, cfg_dwell,
    input  last_idx, loop_en, start, stop,
    output wave_sel, freq_ctrl, duty_cycle, gen_rst, busy, done, cur_idx
  );

  modport master (
    output cfg_we, cfg_addr, cfg_wave_sel, cfg_freq, cfg_duty, cfg_dwell,
    output last_idx, loop_en, start, stop,
    input  wave_sel, freq_ctrl, duty_cycle, gen_rst, busy, done, cur_idx
  );
endinterface

// File: rtl/wave_sequencer.sv
// Profile sequencer for WaveGenerator: plays a table of (wave_sel, freq, duty, dwell)
// entries in order, holding the generator in reset for one LOAD cycle between profiles.
module wave_sequencer #(
  parameter int unsigned N     = 32,
  parameter int unsigned D     = 24,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  wave_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DWELL = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_tab_sel   [DEPTH];
  logic [N-1:0]  r_tab_freq  [DEPTH];
  logic [N-1:0]  r_tab_duty  [DEPTH];
  logic [D-1:0]  r_tab_dwell [DEPTH];

  logic [1:0]    r_wave_sel;
  logic [N-1:0]  r_freq_ctrl;
  logic [N-1:0]  r_duty_cycle;
  logic          r_gen_rst;
  logic          r_busy;
  logic          r_done;
  logic [AW-1:0] r_cur_idx;
  logic [D-1:0]  r_cnt;

  logic [D-1:0]  w_dwell;

  assign w_dwell = r_tab_dwell[r_cur_idx];

  // Profile table: never reset, so host configuration survives rst.
  always_ff @(posedge clk) begin
    if (bus.cfg_we) begin
      r_tab_sel[bus.cfg_addr]   <= bus.cfg_wave_sel;
      r_tab_freq[bus.cfg_addr]  <= bus.cfg_freq;
      r_tab_duty[bus.cfg_addr]  <= bus.cfg_duty;
      r_tab_dwell[bus.cfg_addr] <= bus.cfg_dwell;
    end
  end

  // Sequencing FSM; stop outranks dwell expiry and start is only honoured in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wave_sel   <= 2'd0;
      r_freq_ctrl  <= '0;
      r_duty_cycle <= '0;
      r_gen_rst    <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cur_idx    <= '0;
      r_cnt        <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.stop) begin
            r_state   <= S_LOAD;
            r_cur_idx <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.stop) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_gen_rst <= 1'b1;
          end else begin
            r_state      <= S_DWELL;
            r_wave_sel   <= r_tab_sel[r_cur_idx];
            r_freq_ctrl  <= r_tab_freq[r_cur_idx];
            r_duty_cycle <= r_tab_duty[r_cur_idx];
            r_gen_rst    <= 1'b0;
            r_cnt        <= (w_dwell == '0) ? '0 : w_dwell - D'(1);
          end
        end
        S_DWELL: begin
          if (bus.stop) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_gen_rst <= 1'b1;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - D'(1);
          end else begin
            r_gen_rst <= 1'b1;
            if (r_cur_idx != bus.last_idx) begin
              r_state   <= S_LOAD;
              r_cur_idx <= r_cur_idx + AW'(1);
            end else if (bus.loop_en) begin
              r_state   <= S_LOAD;
              r_cur_idx <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_gen_rst <= 1'b1;
        end
      endcase
    end
  end

  assign bus.wave_sel   = r_wave_sel;
  assign bus.freq_ctrl  = r_freq_ctrl;
  assign bus.duty_cycle = r_duty_cycle;
  assign bus.gen_rst    = r_gen_rst;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.cur_idx    = r_cur_idx;

endmodule

// File: tb/tb_wave_sequencer.sv
// Bench for wave_sequencer: directed scenarios plus random traffic, every cycle compared
// against a schedule-expanding reference model of the profile playback.
module tb_wave_sequencer;

  logic clk;
  logic rst;

  wave_sequencer_if #(.N(32), .D(24), .AW(3)) bus ();

  wave_sequencer #(.N(32), .D(24), .DEPTH(8), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] freq;
    logic [31:0] duty;
  } rec_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state: table copy, expected outputs, and the pending dwell schedule.
  logic [1:0]  t_sel   [8];
  logic [31:0] t_freq  [8];
  logic [31:0] t_duty  [8];
  logic [23:0] t_dwell [8];
  logic [1:0]  e_sel;
  logic [31:0] e_freq, e_duty;
  logic        e_grst, e_busy, e_done;
  logic [2:0]  e_cur;
  bit          m_run, m_pend;
  rec_t        sched[$];

  int lows, dones, idles, period, last_l0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    e_sel = 2'd0; e_freq = 32'd0; e_duty = 32'd0;
    e_grst = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_cur = 3'd0;
    m_run = 1'b0; m_pend = 1'b0;
    sched.delete();
  endtask

  task automatic model_edge();
    rec_t r;
    int   n;
    if (rst) begin
      model_reset();
      return;
    end
    e_done = 1'b0;
    if (!m_run) begin
      if (bus.start && !bus.stop) begin
        m_run = 1'b1; m_pend = 1'b1; e_cur = 3'd0; e_busy = 1'b1;
      end
    end else if (bus.stop) begin
      m_run = 1'b0; m_pend = 1'b0; sched.delete();
      e_grst = 1'b1; e_busy = 1'b0;
    end else if (m_pend) begin
      // Expand the whole profile into its dwell cycles using the table as it stood.
      m_pend = 1'b0;
      r.sel = t_sel[e_cur]; r.freq = t_freq[e_cur]; r.duty = t_duty[e_cur];
      n = (t_dwell[e_cur] == 24'd0) ? 1 : int'(t_dwell[e_cur]);
      for (int i = 0; i < n; i++) sched.push_back(r);
      r = sched.pop_front();
      e_sel = r.sel; e_freq = r.freq; e_duty = r.duty; e_grst = 1'b0;
    end else if (sched.size() > 0) begin
      r = sched.pop_front();
      e_sel = r.sel; e_freq = r.freq; e_duty = r.duty; e_grst = 1'b0;
    end else begin
      e_grst = 1'b1;
      if (e_cur != bus.last_idx) begin
        e_cur = e_cur + 3'd1; m_pend = 1'b1;
      end else if (bus.loop_en) begin
        e_cur = 3'd0; m_pend = 1'b1;
      end else begin
        m_run = 1'b0; e_busy = 1'b0; e_done = 1'b1;
      end
    end
    if (bus.cfg_we) begin
      t_sel[bus.cfg_addr]   = bus.cfg_wave_sel;
      t_freq[bus.cfg_addr]  = bus.cfg_freq;
      t_duty[bus.cfg_addr]  = bus.cfg_duty;
      t_dwell[bus.cfg_addr] = bus.cfg_dwell;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wave_sel"},   32'(bus.wave_sel),   32'(e_sel));
    chk({tag, ".freq_ctrl"},  bus.freq_ctrl,       e_freq);
    chk({tag, ".duty_cycle"}, bus.duty_cycle,      e_duty);
    chk({tag, ".gen_rst"},    32'(bus.gen_rst),    32'(e_grst));
    chk({tag, ".busy"},       32'(bus.busy),       32'(e_busy));
    chk({tag, ".done"},       32'(bus.done),       32'(e_done));
    chk({tag, ".cur_idx"},    32'(bus.cur_idx),    32'(e_cur));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_all("trace");
  endtask

  task automatic clr_cnt();
    lows = 0; dones = 0; idles = 0; period = -1; last_l0 = -1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.gen_rst === 1'b0) lows++;
      if (bus.done === 1'b1) dones++;
      if (bus.busy !== 1'b1) idles++;
      if (bus.cur_idx === 3'd0 && bus.gen_rst === 1'b1 && bus.busy === 1'b1) begin
        if (last_l0 >= 0) period = cyc - last_l0;
        last_l0 = cyc;
      end
    end
  endtask

  task automatic wait_for(input logic [2:0] idx, input logic g, input string tag);
    int k;
    for (k = 0; k < 100 && !(bus.cur_idx === idx && bus.gen_rst === g); k++) tick();
    chk({tag, ".timeout"}, 32'(k < 100), 32'd1);
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [1:0] s,
                             input logic [31:0] f, input logic [31:0] d, input logic [23:0] dw);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wave_sel = s;
    bus.cfg_freq = f; bus.cfg_duty = d; bus.cfg_dwell = dw;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = 3'd0; bus.cfg_wave_sel = 2'd0;
    bus.cfg_freq = 32'd0; bus.cfg_duty = 32'd0; bus.cfg_dwell = 24'd0;
    bus.last_idx = 3'd0; bus.loop_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    for (int k = 3; k < 8; k++)
      write_entry(3'(k), 2'(k), 32'h100 * 32'(k), 32'h10 * 32'(k), 24'd5);
    write_entry(3'd0, 2'b00, 32'h1000, 32'h0100, 24'd4);
    write_entry(3'd1, 2'b10, 32'h2000, 32'h0200, 24'd3);
    write_entry(3'd2, 2'b11, 32'h4000, 32'h0300, 24'd2);

    // One-shot over entries 0..2
    bus.last_idx = 3'd2; bus.loop_en = 1'b0;
    clr_cnt(); pulse_start(); run(14);
    chk("t1.low_cycles", 32'(lows), 32'd9);
    chk("t1.done_count", 32'(dones), 32'd1);
    chk("t1.busy_end", 32'(bus.busy), 32'd0);

    // Looping: period 12, no done, busy held
    bus.loop_en = 1'b1;
    pulse_start(); clr_cnt(); run(40);
    chk("t2.done_count", 32'(dones), 32'd0);
    chk("t2.idle_cycles", 32'(idles), 32'd0);
    chk("t2.period", 32'(period), 32'd12);
    pulse_stop(); tick();

    // Stop in the 2nd DWELL cycle of entry 1
    bus.loop_en = 1'b0;
    pulse_start();
    wait_for(3'd1, 1'b0, "t3.wait");
    tick();
    pulse_stop();
    chk("t3.freq_hold", bus.freq_ctrl, 32'h2000);
    chk("t3.gen_rst", 32'(bus.gen_rst), 32'd1);
    chk("t3.busy", 32'(bus.busy), 32'd0);
    chk("t3.done", 32'(bus.done), 32'd0);
    pulse_start();
    chk("t3.restart_idx", 32'(bus.cur_idx), 32'd0);
    chk("t3.restart_busy", 32'(bus.busy), 32'd1);
    run(16);

    // Zero dwell behaves as one cycle
    write_entry(3'd0, 2'b00, 32'h1000, 32'h0100, 24'd0);
    bus.last_idx = 3'd0;
    pulse_start(); clr_cnt(); run(5);
    chk("t4.low_cycles", 32'(lows), 32'd1);
    chk("t4.done_count", 32'(dones), 32'd1);
    write_entry(3'd0, 2'b00, 32'h1000, 32'h0100, 24'd4);

    // Write during LOAD of entry 1: old data now, new data next pass
    bus.last_idx = 3'd2; bus.loop_en = 1'b1;
    pulse_start();
    wait_for(3'd1, 1'b1, "t5.wait_load");
    write_entry(3'd1, 2'b10, 32'h5555, 32'h0200, 24'd3);
    chk("t5.old_freq", bus.freq_ctrl, 32'h2000);
    wait_for(3'd0, 1'b1, "t5.wait_wrap");
    wait_for(3'd1, 1'b0, "t5.wait_pass2");
    chk("t5.new_freq", bus.freq_ctrl, 32'h5555);
    pulse_stop(); tick();
    write_entry(3'd1, 2'b10, 32'h2000, 32'h0200, 24'd3);

    // Asynchronous reset mid-DWELL, then replay
    bus.loop_en = 1'b0;
    pulse_start();
    wait_for(3'd1, 1'b0, "t6.wait");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("t6.async");
    tick();
    rst = 1'b0;
    tick();
    clr_cnt(); pulse_start(); run(14);
    chk("t6.low_cycles", 32'(lows), 32'd9);
    chk("t6.done_count", 32'(dones), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.cfg_we = ($urandom_range(0, 3) == 0);
      bus.cfg_addr = 3'($urandom_range(0, 7));
      bus.cfg_wave_sel = 2'($urandom_range(0, 3));
      bus.cfg_freq = $urandom;
      bus.cfg_duty = $urandom;
      bus.cfg_dwell = 24'($urandom_range(0, 4));
      bus.start = ($urandom_range(0, 9) == 0);
      bus.stop = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) bus.last_idx = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) bus.loop_en = 1'($urandom_range(0, 1));
      tick();
    end
    bus.cfg_we = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
